datapath_sequencer: RTL and testbench

- Multi-cycle control unit that sequences the single-bus datapath: PC, IR, HI, LO, R0-R15, Y, Z, MAR, MDR, INPORT and OUTPORT.
- Runs fetch (T0-T2), decode and execute (T3-T7) for each instruction. Each cycle it drives one bus source, the register load enables, the ALU opcode and the memory strobes.
- Sits beside the datapath and owns the run/halt indicator.

---
 rtl/datapath_sequencer_if.sv | 33 +++
 rtl/datapath_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_if.sv
// Sequencer <-> datapath bundle: IR/flag/memory/stop inputs and the
// per-cycle control word (bus source, loads, ALU op, strobes, status).
interface datapath_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic [DATA_W-1:0] ir;
  logic              con_ff;
  logic              mem_ready;
  logic              stop;
  logic [3:0]        bus_src;
  logic [IDX_W-1:0]  gpr_sel;
  logic [10:0]       load_en;
  logic              mem_read;
  logic              mem_write;
  logic [4:0]        alu_op;
  logic              run;
  logic              illegal;

  modport master (
    output ir, con_ff, mem_ready, stop,
    input  bus_src, gpr_sel, load_en,
    input  mem_read, mem_write, alu_op,
    input  run, illegal
  );

  modport slave (
    input  ir, con_ff, mem_ready, stop,
    output bus_src, gpr_sel, load_en,
    output mem_read, mem_write, alu_op,
    output run, illegal
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the single-bus datapath.
// Ports: clock, clear (async, active-low), bus (slave side of the bundle).
module datapath_sequencer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic clock,
  input  logic clear,
  datapath_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [3:0] B_PC  = 4'd1;
  localparam logic [3:0] B_MDR = 4'd2;
  localparam logic [3:0] B_ZHI = 4'd3;
  localparam logic [3:0] B_ZLO = 4'd4;
  localparam logic [3:0] B_HI  = 4'd5;
  localparam logic [3:0] B_LO  = 4'd6;
  localparam logic [3:0] B_GPR = 4'd7;
  localparam logic [3:0] B_BA  = 4'd8;
  localparam logic [3:0] B_C   = 4'd9;
  localparam logic [3:0] B_IN  = 4'd10;

  localparam int L_PC  = 0;
  localparam int L_IR  = 1;
  localparam int L_MAR = 2;
  localparam int L_MDR = 3;
  localparam int L_Y   = 4;
  localparam int L_Z   = 5;
  localparam int L_HI  = 6;
  localparam int L_LO  = 7;
  localparam int L_GPR = 8;
  localparam int L_OUT = 9;
  localparam int L_CON = 10;

  localparam logic [4:0] ALU_INC = 5'h1F;
  localparam logic [4:0] ALU_ADD = 5'h03;

  state_t r_state;
  state_t w_last;
  logic   r_take;

  logic [4:0]       w_op;
  logic [IDX_W-1:0] w_ra;
  logic [IDX_W-1:0] w_rb;
  logic [IDX_W-1:0] w_rc;
  logic             w_unused_ir;

  assign w_op = bus.ir[31:27];
  assign w_ra = IDX_W'(bus.ir[26:23]);
  assign w_rb = IDX_W'(bus.ir[22:19]);
  assign w_rc = IDX_W'(bus.ir[18:15]);
  assign w_unused_ir = ^bus.ir;

  logic w_c_ld, w_c_ldi, w_c_st;
  logic w_c_alur, w_c_alui;
  logic w_c_muld, w_c_unary;
  logic w_c_br, w_c_jr, w_c_jal;
  logic w_c_in, w_c_out;
  logic w_c_mfhi, w_c_mflo;
  logic w_c_nop, w_c_halt, w_c_ill;

  assign w_c_ld    = (w_op == 5'h00);
  assign w_c_ldi   = (w_op == 5'h01);
  assign w_c_st    = (w_op == 5'h02);
  assign w_c_alur  = (w_op >= 5'h03) && (w_op <= 5'h0B);
  assign w_c_alui  = (w_op >= 5'h0C) && (w_op <= 5'h0E);
  assign w_c_muld  = (w_op == 5'h0F) || (w_op == 5'h10);
  assign w_c_unary = (w_op == 5'h11) || (w_op == 5'h12);
  assign w_c_br    = (w_op == 5'h13);
  assign w_c_jr    = (w_op == 5'h14);
  assign w_c_jal   = (w_op == 5'h15);
  assign w_c_in    = (w_op == 5'h16);
  assign w_c_out   = (w_op == 5'h17);
  assign w_c_mfhi  = (w_op == 5'h18);
  assign w_c_mflo  = (w_op == 5'h19);
  assign w_c_nop   = (w_op == 5'h1A);
  assign w_c_halt  = (w_op == 5'h1B);
  assign w_c_ill   = (w_op >= 5'h1C);

  // Final execute step for each opcode class.
  always_comb begin
    w_last = S_T3;
    unique case (1'b1)
      w_c_ld, w_c_st:               w_last = S_T7;
      w_c_muld, w_c_br:             w_last = S_T6;
      w_c_alur, w_c_alui, w_c_ldi:  w_last = S_T5;
      w_c_unary, w_c_jal:           w_last = S_T4;
      default:                      w_last = S_T3;
    endcase
  end

  logic w_wait;
  assign w_wait = !bus.mem_ready &&
                  ((r_state == S_T6 && w_c_ld) ||
                   (r_state == S_T7 && w_c_st));

  // r_take captures con_ff on the T5->T6 edge so the branch PC load
  // in T6 depends on state only, never directly on an input.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RST;
      r_take  <= 1'b0;
    end else begin
      if (r_state == S_T5) r_take <= bus.con_ff;
      unique case (r_state)
        S_RST:  r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (bus.mem_ready) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_HALT: r_state <= S_HALT;
        default: begin
          if (r_state == S_T3 && w_c_halt)
            r_state <= S_HALT;
          else if (w_wait)
            r_state <= r_state;
          else if (r_state >= w_last)
            r_state <= bus.stop ? S_HALT : S_T0;
          else
            r_state <= state_t'(r_state + 4'd1);
        end
      endcase
    end
  end

  logic [3:0]       w_bus;
  logic [IDX_W-1:0] w_sel;
  logic [10:0]      w_load;
  logic             w_mrd;
  logic             w_mwr;
  logic [4:0]       w_alu;
  logic             w_run;
  logic             w_ill;

  always_comb begin
    w_bus  = '0;
    w_sel  = '0;
    w_load = '0;
    w_mrd  = 1'b0;
    w_mwr  = 1'b0;
    w_alu  = '0;
    w_run  = 1'b0;
    w_ill  = 1'b0;
    unique case (r_state)
      S_RST, S_HALT: begin
      end
      S_T0: begin
        w_run = 1'b1;
        w_bus = B_PC;
        w_load[L_MAR] = 1'b1;
        w_load[L_Z]   = 1'b1;
        w_alu = ALU_INC;
      end
      S_T1: begin
        w_run = 1'b1;
        w_bus = B_ZLO;
        w_load[L_PC]  = 1'b1;
        w_load[L_MDR] = 1'b1;
        w_mrd = 1'b1;
      end
      S_T2: begin
        w_run = 1'b1;
        w_bus = B_MDR;
        w_load[L_IR] = 1'b1;
      end
      default: begin
        w_run = 1'b1;
        unique case (1'b1)
          w_c_alur, w_c_alui: begin
            case (r_state)
              S_T3: begin
                w_bus = B_GPR; w_sel = w_rb;
                w_load[L_Y] = 1'b1;
              end
              S_T4: begin
                w_bus = w_c_alui ? B_C : B_GPR;
                w_sel = w_c_alui ? '0 : w_rc;
                w_alu = w_op;
                w_load[L_Z] = 1'b1;
              end
              S_T5: begin
                w_bus = B_ZLO; w_sel = w_ra;
                w_load[L_GPR] = 1'b1;
              end
              default: begin
              end
            endcase
          end
          w_c_unary: begin
            case (r_state)
              S_T3: begin
                w_bus = B_GPR; w_sel = w_rb;
                w_alu = w_op;
                w_load[L_Z] = 1'b1;
              end
              S_T4: begin
                w_bus = B_ZLO; w_sel = w_ra;
                w_load[L_GPR] = 1'b1;
              end
              default: begin
              end
            endcase
          end
          w_c_muld: begin
            case (r_state)
              S_T3: begin
                w_bus = B_GPR; w_sel = w_ra;
                w_load[L_Y] = 1'b1;
              end
              S_T4: begin
                w_bus = B_GPR; w_sel = w_rb;
                w_alu = w_op;
                w_load[L_Z] = 1'b1;
              end
              S_T5: begin
                w_bus = B_ZLO;
                w_load[L_LO] = 1'b1;
              end
              S_T6: begin
                w_bus = B_ZHI;
                w_load[L_HI] = 1'b1;
              end
              default: begin
              end
            endcase
          end
          w_c_ld, w_c_ldi, w_c_st: begin
            case (r_state)
              S_T3: begin
                w_bus = B_BA; w_sel = w_rb;
                w_load[L_Y] = 1'b1;
              end
              S_T4: begin
                w_bus = B_C;
                w_alu = ALU_ADD;
                w_load[L_Z] = 1'b1;
              end
              S_T5: begin
                w_bus = B_ZLO;
                if (w_c_ldi) begin
                  w_sel = w_ra;
                  w_load[L_GPR] = 1'b1;
                end else begin
                  w_load[L_MAR] = 1'b1;
                end
              end
              S_T6: begin
                if (w_c_st) begin
                  w_bus = B_GPR; w_sel = w_ra;
                end else begin
                  w_mrd = 1'b1;
                end
                w_load[L_MDR] = 1'b1;
              end
              S_T7: begin
                if (w_c_st) begin
                  w_mwr = 1'b1;
                end else begin
                  w_bus = B_MDR; w_sel = w_ra;
                  w_load[L_GPR] = 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
          w_c_br: begin
            case (r_state)
              S_T3: begin
                w_bus = B_GPR; w_sel = w_ra;
                w_load[L_CON] = 1'b1;
              end
              S_T4: begin
                w_bus = B_PC;
                w_load[L_Y] = 1'b1;
              end
              S_T5: begin
                w_bus = B_C;
                w_alu = ALU_ADD;
                w_load[L_Z] = 1'b1;
              end
              S_T6: begin
                w_bus = B_ZLO;
                w_load[L_PC] = r_take;
              end
              default: begin
              end
            endcase
          end
          w_c_jr: begin
            if (r_state == S_T3) begin
              w_bus = B_GPR; w_sel = w_ra;
              w_load[L_PC] = 1'b1;
            end
          end
          w_c_jal: begin
            if (r_state == S_T3) begin
              w_bus = B_PC; w_sel = IDX_W'(4'hF);
              w_load[L_GPR] = 1'b1;
            end else if (r_state == S_T4) begin
              w_bus = B_GPR; w_sel = w_ra;
              w_load[L_PC] = 1'b1;
            end
          end
          w_c_in, w_c_mfhi, w_c_mflo: begin
            if (r_state == S_T3) begin
              w_bus = w_c_in   ? B_IN :
                      w_c_mfhi ? B_HI : B_LO;
              w_sel = w_ra;
              w_load[L_GPR] = 1'b1;
            end
          end
          w_c_out: begin
            if (r_state == S_T3) begin
              w_bus = B_GPR; w_sel = w_ra;
              w_load[L_OUT] = 1'b1;
            end
          end
          w_c_ill: begin
            w_ill = (r_state == S_T3);
          end
          default: begin
          end
        endcase
      end
    endcase
  end

  assign bus.bus_src   = w_bus;
  assign bus.gpr_sel   = w_sel;
  assign bus.load_en   = w_load;
  assign bus.mem_read  = w_mrd;
  assign bus.mem_write = w_mwr;
  assign bus.alu_op    = w_alu;
  assign bus.run       = w_run;
  assign bus.illegal   = w_ill;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: fetch, execute classes,
// memory waits, branch, halt/stop/clear and illegal opcode.
module tb_datapath_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  datapath_sequencer_if u_if ();

  datapath_sequencer u_dut (
    .clock (clock),
    .clear (clear),
    .bus   (u_if.slave)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] LPC  = 11'h001;
  localparam logic [10:0] LIR  = 11'h002;
  localparam logic [10:0] LMAR = 11'h004;
  localparam logic [10:0] LMDR = 11'h008;
  localparam logic [10:0] LY   = 11'h010;
  localparam logic [10:0] LZ   = 11'h020;
  localparam logic [10:0] LHI  = 11'h040;
  localparam logic [10:0] LLO  = 11'h080;
  localparam logic [10:0] LGPR = 11'h100;
  localparam logic [10:0] LOUT = 11'h200;
  localparam logic [10:0] LCON = 11'h400;

  function automatic logic [27:0] snap();
    return {u_if.bus_src, u_if.gpr_sel, u_if.load_en,
            u_if.mem_read, u_if.mem_write, u_if.alu_op,
            u_if.run, u_if.illegal};
  endfunction

  // Expected control word for a running state.
  function automatic logic [27:0] ex(
    input logic [3:0] b, input logic [3:0] g,
    input logic [10:0] l, input logic mr, input logic mw,
    input logic [4:0] a, input logic ill);
    return {b, g, l, mr, mw, a, 1'b1, ill};
  endfunction

  function automatic logic [31:0] enc(
    input logic [4:0] op, input logic [3:0] ra,
    input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  logic [27:0] E_T0;
  logic [27:0] E_T1;
  logic [27:0] E_T2;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From an observed T0, run the fetch and stop at T3.
  task automatic do_fetch(input logic [31:0] v);
    u_if.mem_ready = 1'b1;
    u_if.ir = v;
    step(); step(); step();
  endtask

  task automatic test_reset();
    #2 clear = 1'b0;
    step(); step();
    checks++;
    if (snap() !== 28'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", snap(), 28'h0);
    end
    clear = 1'b1;
    step();
    checks++;
    if (snap() !== E_T0) begin
      errors++;
      $display("FAIL fetch_t0: got %h want %h", snap(), E_T0);
    end
    u_if.mem_ready = 1'b1;
    step();
    checks++;
    if (snap() !== E_T1) begin
      errors++;
      $display("FAIL fetch_t1: got %h want %h", snap(), E_T1);
    end
    step();
    checks++;
    if (snap() !== E_T2) begin
      errors++;
      $display("FAIL fetch_t2: got %h want %h", snap(), E_T2);
    end
    u_if.ir = enc(5'h1A, 4'd0, 4'd0, 19'd0);
    step();
    checks++;
    if (snap() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL nop_t3: got %h want %h", snap(),
               ex(0, 0, 0, 0, 0, 0, 0));
    end
    step();
  endtask

  task automatic test_mem_wait();
    u_if.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== E_T1) begin
        errors++;
        $display("FAIL t1_wait[%0d]: got %h want %h", i, snap(), E_T1);
      end
    end
    u_if.mem_ready = 1'b1;
    step();
    checks++;
    if (snap() !== E_T2) begin
      errors++;
      $display("FAIL t1_release: got %h want %h", snap(), E_T2);
    end
    u_if.ir = enc(5'h1A, 4'd0, 4'd0, 19'd0);
    step(); step();
  endtask

  task automatic test_alu();
    logic [27:0] e [$];
    do_fetch(enc(5'h03, 4'd2, 4'd3, {4'd4, 15'd0}));
    e = '{ex(7, 3, LY, 0, 0, 0, 0), ex(7, 4, LZ, 0, 0, 5'h03, 0),
          ex(4, 2, LGPR, 0, 0, 0, 0), E_T0};
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL add[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
    do_fetch(enc(5'h0C, 4'd1, 4'd2, 19'h00055));
    e = '{ex(7, 2, LY, 0, 0, 0, 0), ex(9, 0, LZ, 0, 0, 5'h0C, 0),
          ex(4, 1, LGPR, 0, 0, 0, 0), E_T0};
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL addi[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
    do_fetch(enc(5'h11, 4'd1, 4'd2, 19'd0));
    e = '{ex(7, 2, LZ, 0, 0, 5'h11, 0), ex(4, 1, LGPR, 0, 0, 0, 0),
          E_T0};
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL neg[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
  endtask

  task automatic test_ld_st();
    logic [27:0] e [$];
    do_fetch(enc(5'h00, 4'd1, 4'd0, 19'h10));
    e = '{ex(8, 0, LY, 0, 0, 0, 0), ex(9, 0, LZ, 0, 0, 5'h03, 0),
          ex(4, 0, LMAR, 0, 0, 0, 0)};
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL ld[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
    u_if.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== ex(0, 0, LMDR, 1, 0, 0, 0)) begin
        errors++;
        $display("FAIL ld_t6_wait[%0d]: got %h want %h", i, snap(),
                 ex(0, 0, LMDR, 1, 0, 0, 0));
      end
    end
    u_if.mem_ready = 1'b1;
    e = '{ex(2, 1, LGPR, 0, 0, 0, 0), E_T0};
    for (int i = 0; i < e.size(); i++) begin
      step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL ld_tail[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
    do_fetch(enc(5'h02, 4'd1, 4'd2, 19'h20));
    e = '{ex(8, 2, LY, 0, 0, 0, 0), ex(9, 0, LZ, 0, 0, 5'h03, 0),
          ex(4, 0, LMAR, 0, 0, 0, 0), ex(7, 1, LMDR, 0, 0, 0, 0),
          ex(0, 0, 0, 0, 1, 0, 0), E_T0};
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL st[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
  endtask

  task automatic test_branch_mul();
    logic [27:0] e [$];
    for (int c = 0; c < 2; c++) begin
      u_if.con_ff = (c == 1);
      do_fetch(enc(5'h13, 4'd5, 4'd0, 19'h4));
      e = '{ex(7, 5, LCON, 0, 0, 0, 0), ex(1, 0, LY, 0, 0, 0, 0),
            ex(9, 0, LZ, 0, 0, 5'h03, 0),
            ex(4, 0, (c == 1) ? LPC : 11'h0, 0, 0, 0, 0), E_T0};
      for (int i = 0; i < e.size(); i++) begin
        if (i > 0) step();
        checks++;
        if (snap() !== e[i]) begin
          errors++;
          $display("FAIL br_con%0d[%0d]: got %h want %h", c, i,
                   snap(), e[i]);
        end
      end
    end
    u_if.con_ff = 1'b0;
    do_fetch(enc(5'h0F, 4'd6, 4'd7, 19'd0));
    e = '{ex(7, 6, LY, 0, 0, 0, 0), ex(7, 7, LZ, 0, 0, 5'h0F, 0),
          ex(4, 0, LLO, 0, 0, 0, 0), ex(3, 0, LHI, 0, 0, 0, 0), E_T0};
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== e[i]) begin
        errors++;
        $display("FAIL mul[%0d]: got %h want %h", i, snap(), e[i]);
      end
    end
  endtask

  task automatic test_single_step();
    logic [31:0] iv [5];
    logic [27:0] e  [5];
    logic [27:0] j  [$];
    iv = '{enc(5'h14, 4'd9, 4'd0, 19'd0), enc(5'h16, 4'd3, 4'd0, 19'd0),
           enc(5'h17, 4'd4, 4'd0, 19'd0), enc(5'h18, 4'd5, 4'd0, 19'd0),
           enc(5'h19, 4'd6, 4'd0, 19'd0)};
    e  = '{ex(7, 9, LPC, 0, 0, 0, 0), ex(10, 3, LGPR, 0, 0, 0, 0),
           ex(7, 4, LOUT, 0, 0, 0, 0), ex(5, 5, LGPR, 0, 0, 0, 0),
           ex(6, 6, LGPR, 0, 0, 0, 0)};
    for (int k = 0; k < 5; k++) begin
      do_fetch(iv[k]);
      checks++;
      if (snap() !== e[k]) begin
        errors++;
        $display("FAIL single[%0d]: got %h want %h", k, snap(), e[k]);
      end
      step();
      checks++;
      if (snap() !== E_T0) begin
        errors++;
        $display("FAIL single_ret[%0d]: got %h want %h", k, snap(), E_T0);
      end
    end
    do_fetch(enc(5'h15, 4'd8, 4'd0, 19'd0));
    j = '{ex(1, 15, LGPR, 0, 0, 0, 0), ex(7, 8, LPC, 0, 0, 0, 0), E_T0};
    for (int i = 0; i < j.size(); i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== j[i]) begin
        errors++;
        $display("FAIL jal[%0d]: got %h want %h", i, snap(), j[i]);
      end
    end
  endtask

  task automatic test_illegal();
    do_fetch(enc(5'h1E, 4'd0, 4'd0, 19'd0));
    checks++;
    if (snap() !== ex(0, 0, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL illegal_t3: got %h want %h", snap(),
               ex(0, 0, 0, 0, 0, 0, 1));
    end
    step();
    checks++;
    if (snap() !== E_T0) begin
      errors++;
      $display("FAIL illegal_ret: got %h want %h", snap(), E_T0);
    end
  endtask

  task automatic test_stop();
    do_fetch(enc(5'h1A, 4'd0, 4'd0, 19'd0));
    u_if.stop = 1'b1;
    step();
    u_if.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step();
      checks++;
      if (snap() !== 28'h0) begin
        errors++;
        $display("FAIL stop_halt[%0d]: got %h want %h", i, snap(), 28'h0);
      end
    end
    clear = 1'b0;
    #1 clear = 1'b1;
    step();
    checks++;
    if (snap() !== E_T0) begin
      errors++;
      $display("FAIL stop_restart: got %h want %h", snap(), E_T0);
    end
  endtask

  task automatic test_halt();
    do_fetch(enc(5'h1B, 4'd0, 4'd0, 19'd0));
    checks++;
    if (snap() !== ex(0, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL halt_t3: got %h want %h", snap(),
               ex(0, 0, 0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (snap() !== 28'h0) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %h want %h", i, snap(), 28'h0);
      end
    end
    clear = 1'b0;
    #1 clear = 1'b1;
    step();
    checks++;
    if (snap() !== E_T0) begin
      errors++;
      $display("FAIL halt_restart: got %h want %h", snap(), E_T0);
    end
  endtask

  task automatic test_abort();
    do_fetch(enc(5'h03, 4'd2, 4'd3, {4'd4, 15'd0}));
    step();
    clear = 1'b0;
    #1;
    checks++;
    if (snap() !== 28'h0) begin
      errors++;
      $display("FAIL abort_clear: got %h want %h", snap(), 28'h0);
    end
    clear = 1'b1;
    step();
    checks++;
    if (snap() !== E_T0) begin
      errors++;
      $display("FAIL abort_restart: got %h want %h", snap(), E_T0);
    end
  endtask

  initial begin
    u_if.ir        = '0;
    u_if.con_ff    = 1'b0;
    u_if.mem_ready = 1'b1;
    u_if.stop      = 1'b0;
    E_T0 = ex(1, 0, LMAR | LZ, 0, 0, 5'h1F, 0);
    E_T1 = ex(4, 0, LPC | LMDR, 1, 0, 0, 0);
    E_T2 = ex(2, 0, LIR, 0, 0, 0, 0);
    test_reset();
    test_mem_wait();
    test_alu();
    test_ld_st();
    test_branch_mul();
    test_single_step();
    test_illegal();
    test_stop();
    test_halt();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
